// File: rtl/cactus_gen_pkg.sv
// Shared definitions for the cactus obstacle engine.
//   - Default screen/cactus geometry (also used by the pixel and dino stages).
//   - Spawn FSM state type, exposed on the debug port of cactus_gen.
//   - Galois LFSR step function used by lfsr16.
package cactus_gen_pkg;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_GROUND_Y = 400;
  localparam int DEF_CACTUS_W = 16;
  localparam int DEF_TALL_H   = 40;
  localparam int DEF_SHORT_H  = 24;
  localparam int DEF_MIN_GAP  = 200;

  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 in Galois form.
  localparam logic [15:0] LFSR_MASK     = 16'hB400;

  typedef enum logic {
    ST_GAP   = 1'b0,
    ST_SPAWN = 1'b1
  } spawn_state_t;

  // One Galois shift: the bit falling out of the bottom is fed back
  // through the tap mask. A non-zero state never maps to zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_MASK) : (cur >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with enable. Reset loads the seed; each enabled clock
// advances one step. Shared by the cactus spawner and (later) the bird.
// Ports:
//   clk   in   clock
//   rst_n in   asynchronous active-low reset (loads seed)
//   en    in   advance one step this cycle
//   seed  in   reset value, must be non-zero
//   q     out  current LFSR state
module lfsr16
  import cactus_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= seed;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/cactus_gen.sv
// Cactus obstacle engine. Keeps up to NUM_SLOTS cacti, scrolls them left by
// 'speed' pixels on every running frame_tick and spawns new ones at the right
// edge after a pseudo-random scrolled gap. black_cactus is a zero-latency hit
// test of the current pixel against all active cacti.
// Ports:
//   clk, rst_n   pixel clock, asynchronous active-low reset
//   frame_tick   one-cycle pulse per frame (start of vblank)
//   run          1 = game running, 0 = everything frozen (still drawn)
//   clear        synchronous restart: empty slots, gap_cnt=0, FSM=GAP
//   speed        scroll pixels per frame
//   h_cnt, v_cnt current pixel column / row
//   black_cactus current pixel lies inside an active cactus
//   active_mask  slot valid bits
//   dbg_state, dbg_gap_cnt, dbg_lfsr, dbg_x, dbg_tall
//                internal state for observation only
module cactus_gen
  import cactus_gen_pkg::*;
#(
  parameter int          NUM_SLOTS = 3,
  parameter int          SCREEN_W  = DEF_SCREEN_W,
  parameter int          GROUND_Y  = DEF_GROUND_Y,
  parameter int          CACTUS_W  = DEF_CACTUS_W,
  parameter int          TALL_H    = DEF_TALL_H,
  parameter int          SHORT_H   = DEF_SHORT_H,
  parameter int          MIN_GAP   = DEF_MIN_GAP,
  parameter logic [15:0] LFSR_SEED = DEF_LFSR_SEED
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_tick,
  input  logic                       run,
  input  logic                       clear,
  input  logic [3:0]                 speed,
  input  logic [9:0]                 h_cnt,
  input  logic [9:0]                 v_cnt,
  output logic                       black_cactus,
  output logic [NUM_SLOTS-1:0]       active_mask,
  output spawn_state_t               dbg_state,
  output logic [9:0]                 dbg_gap_cnt,
  output logic [15:0]                dbg_lfsr,
  output logic [NUM_SLOTS-1:0][10:0] dbg_x,
  output logic [NUM_SLOTS-1:0]       dbg_tall
);

  localparam logic signed [10:0] X_SPAWN     = 11'(SCREEN_W);
  localparam logic signed [10:0] X_EXIT      = 11'(-CACTUS_W);
  localparam logic signed [10:0] X_WIDTH     = 11'(CACTUS_W);
  localparam logic [9:0]         Y_GROUND    = 10'(GROUND_Y);
  localparam logic [9:0]         Y_TALL_TOP  = 10'(GROUND_Y - TALL_H);
  localparam logic [9:0]         Y_SHORT_TOP = 10'(GROUND_Y - SHORT_H);
  localparam logic [9:0]         GAP_BASE    = 10'(MIN_GAP);
  localparam logic [9:0]         GAP_MAX     = 10'd1023;

  spawn_state_t          state_q, state_d;
  logic [9:0]            gap_q, gap_d, gap_sat, gap_thresh;
  logic [10:0]           gap_sum;
  logic [15:0]           lfsr_q;
  logic                  lfsr_en;
  logic                  advance;
  logic                  spawn_en;
  logic [NUM_SLOTS-1:0]  valid_vec, tall_vec, free_vec, grant, hit_vec;
  logic signed [10:0]    hx;

  // clear wins over a running tick; hold otherwise.
  assign advance = frame_tick && run && !clear;
  assign hx      = $signed({1'b0, h_cnt});

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (lfsr_en),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  // A slot is free only if it was invalid before this tick's move, so a
  // cactus leaving the screen cannot be replaced in the same tick.
  assign free_vec = ~valid_vec;

  // Lowest-index free slot wins.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (free_vec[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign gap_sum    = {1'b0, gap_q} + {7'd0, speed};
  assign gap_sat    = gap_sum[10] ? GAP_MAX : gap_sum[9:0];
  // Threshold uses the LFSR value held before this tick's step.
  assign gap_thresh = GAP_BASE + {2'b00, lfsr_q[7:0]};

  // Spawn FSM. GAP accumulates scrolled distance; once past the random
  // threshold, SPAWN places a cactus on the next running tick that finds a
  // free slot, holding gap_cnt while it waits.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    lfsr_en  = 1'b0;
    spawn_en = 1'b0;
    if (clear) begin
      state_d = ST_GAP;
      gap_d   = '0;
    end else if (advance) begin
      case (state_q)
        ST_GAP: begin
          lfsr_en = 1'b1;
          gap_d   = gap_sat;
          if (gap_sat >= gap_thresh) state_d = ST_SPAWN;
        end
        ST_SPAWN: begin
          if (|free_vec) begin
            spawn_en = 1'b1;
            gap_d    = '0;
            state_d  = ST_GAP;
          end
        end
        default: state_d = ST_GAP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_GAP;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    logic               valid_q, tall_q;
    logic signed [10:0] x_q, x_move;
    logic [9:0]         y_top;

    assign x_move = x_q - $signed({7'd0, speed});

    // A freshly spawned cactus is placed at the right edge unmoved; an
    // existing cactus drops out once its right edge reaches column 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        x_q     <= '0;
        tall_q  <= 1'b0;
      end else if (clear) begin
        valid_q <= 1'b0;
        x_q     <= '0;
        tall_q  <= 1'b0;
      end else if (advance) begin
        if (spawn_en && grant[i]) begin
          valid_q <= 1'b1;
          x_q     <= X_SPAWN;
          tall_q  <= lfsr_q[8];
        end else if (valid_q) begin
          if (x_move > X_EXIT) begin
            x_q <= x_move;
          end else begin
            valid_q <= 1'b0;
            x_q     <= '0;
          end
        end
      end
    end

    assign y_top      = tall_q ? Y_TALL_TOP : Y_SHORT_TOP;
    assign hit_vec[i] = valid_q && (hx >= x_q) && (hx < x_q + X_WIDTH) &&
                        (v_cnt >= y_top) && (v_cnt < Y_GROUND);
    assign valid_vec[i] = valid_q;
    assign tall_vec[i]  = tall_q;
    assign dbg_x[i]     = x_q;
  end

  assign black_cactus = |hit_vec;
  assign active_mask  = valid_vec;
  assign dbg_state    = state_q;
  assign dbg_gap_cnt  = gap_q;
  assign dbg_lfsr     = lfsr_q;
  assign dbg_tall     = tall_vec;

endmodule

// File: tb/tb_cactus_gen.sv
// Bench for cactus_gen: reference model of slots/gap/LFSR kept as plain
// integers, advanced once per frame tick and compared against the DUT.
module tb_cactus_gen;
  import cactus_gen_pkg::*;

  localparam int NS = 3;

  logic                clk = 1'b0;
  logic                rst_n, frame_tick, run, clear;
  logic [3:0]          speed;
  logic [9:0]          h_cnt, v_cnt;
  logic                black_cactus;
  logic [NS-1:0]       active_mask;
  spawn_state_t        dbg_state;
  logic [9:0]          dbg_gap_cnt;
  logic [15:0]         dbg_lfsr;
  logic [NS-1:0][10:0] dbg_x;
  logic [NS-1:0]       dbg_tall;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit          m_valid [NS];
  int          m_x     [NS];
  bit          m_tall  [NS];
  int          m_gap;
  bit          m_spawn;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  cactus_gen dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .clear(clear),
    .speed(speed), .h_cnt(h_cnt), .v_cnt(v_cnt), .black_cactus(black_cactus),
    .active_mask(active_mask), .dbg_state(dbg_state), .dbg_gap_cnt(dbg_gap_cnt),
    .dbg_lfsr(dbg_lfsr), .dbg_x(dbg_x), .dbg_tall(dbg_tall)
  );

  function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic logic [NS-1:0] model_mask();
    logic [NS-1:0] mm;
    for (int i = 0; i < NS; i++) mm[i] = m_valid[i];
    return mm;
  endfunction

  function automatic bit model_pixel(input int h, input int v);
    int ht;
    for (int i = 0; i < NS; i++) begin
      ht = m_tall[i] ? 40 : 24;
      if (m_valid[i] && h >= m_x[i] && h < m_x[i] + 16 && v >= 400 - ht && v <= 399)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 0; m_x[i] = 0; m_tall[i] = 0;
    end
    m_gap = 0; m_spawn = 0; m_lfsr = 16'hACE1;
  endtask

  task automatic model_tick(input bit c, input bit r, input int s);
    bit was_free [NS];
    int thr, slot;
    if (c) begin
      for (int i = 0; i < NS; i++) begin m_valid[i] = 0; m_x[i] = 0; m_tall[i] = 0; end
      m_gap = 0; m_spawn = 0;
      return;
    end
    if (!r) return;
    for (int i = 0; i < NS; i++) was_free[i] = !m_valid[i];
    for (int i = 0; i < NS; i++) begin
      if (m_valid[i]) begin
        m_x[i] = m_x[i] - s;
        if (m_x[i] <= -16) begin m_valid[i] = 0; m_x[i] = 0; end
      end
    end
    if (!m_spawn) begin
      thr    = 200 + int'(m_lfsr[7:0]);
      m_lfsr = ref_lfsr(m_lfsr);
      m_gap  = (m_gap + s > 1023) ? 1023 : m_gap + s;
      if (m_gap >= thr) m_spawn = 1;
    end else begin
      slot = -1;
      for (int i = NS - 1; i >= 0; i--) if (was_free[i]) slot = i;
      if (slot >= 0) begin
        m_valid[slot] = 1; m_x[slot] = 640; m_tall[slot] = m_lfsr[8];
        m_gap = 0; m_spawn = 0;
      end
    end
  endtask

  // One frame tick: inputs change on the falling edge, DUT samples on the
  // rising edge, caller observes at the following falling edge.
  task automatic tick(input bit c, input bit r, input int s);
    @(negedge clk);
    clear = c; run = r; speed = s[3:0]; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0; clear = 1'b0;
    model_tick(c, r, s);
  endtask

  task automatic wait_spawn0(output bit ok);
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      if (m_valid[0]) begin ok = 1; return; end
      tick(0, 1, 15);
    end
  endtask

  task automatic steer(input int slot, input int target, output bit ok);
    int d;
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      if (!m_valid[slot] || m_x[slot] < target) return;
      if (m_x[slot] == target) begin ok = 1; return; end
      d = m_x[slot] - target;
      tick(0, 1, (d > 15) ? 15 : d);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; frame_tick = 0; run = 0; clear = 0; speed = 0; h_cnt = 100; v_cnt = 380;
    repeat (3) @(negedge clk);
    rst_n = 1;
    model_reset();
    @(negedge clk);
    checks++; if (active_mask !== 3'b000) begin failures++; $display("FAIL reset_mask got=%b exp=000", active_mask); end
    checks++; if (black_cactus !== 1'b0) begin failures++; $display("FAIL reset_black got=%b exp=0", black_cactus); end
    checks++; if (dbg_state !== ST_GAP) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    checks++; if (dbg_gap_cnt !== 10'd0) begin failures++; $display("FAIL reset_gap got=%0d exp=0", dbg_gap_cnt); end
    checks++; if (dbg_lfsr !== 16'hACE1) begin failures++; $display("FAIL reset_lfsr got=%h exp=ace1", dbg_lfsr); end
  endtask

  task automatic test_first_spawn();
    for (int t = 0; t < 260; t++) begin
      tick(0, 1, 4);
      checks++; if (dbg_lfsr !== m_lfsr) begin failures++; $display("FAIL spawn_lfsr t=%0d got=%h exp=%h", t, dbg_lfsr, m_lfsr); end
      checks++; if (dbg_gap_cnt !== 10'(m_gap)) begin failures++; $display("FAIL spawn_gap t=%0d got=%0d exp=%0d", t, dbg_gap_cnt, m_gap); end
      checks++; if (dbg_state !== (m_spawn ? ST_SPAWN : ST_GAP)) begin failures++; $display("FAIL spawn_state t=%0d got=%0d exp=%0d", t, dbg_state, m_spawn); end
      checks++; if (active_mask !== model_mask()) begin failures++; $display("FAIL spawn_mask t=%0d got=%b exp=%b", t, active_mask, model_mask()); end
      if (m_valid[0]) begin
        checks++; if (dbg_x[0] !== 11'(m_x[0])) begin failures++; $display("FAIL spawn_x0 t=%0d got=%0d exp=%0d", t, $signed(dbg_x[0]), m_x[0]); end
      end
      if (t >= 59 && m_valid[0] && m_x[0] <= 608) break;
    end
    checks++; if (active_mask[0] !== 1'b1) begin failures++; $display("FAIL spawn_happened got=%b exp=1", active_mask[0]); end
  endtask

  task automatic test_exit();
    bit ok;
    logic [10:0] e;
    tick(1, 1, 0);
    wait_spawn0(ok);
    if (ok) steer(0, -12, ok);
    checks++; if (!ok) begin failures++; $display("FAIL exit_setup got=0 exp=1"); end
    if (ok) begin
      e = 11'(-12);
      checks++; if (dbg_x[0] !== e) begin failures++; $display("FAIL exit_at_m12 got=%0d exp=-12", $signed(dbg_x[0])); end
      tick(0, 1, 4);
      checks++; if (active_mask[0] !== 1'b0) begin failures++; $display("FAIL exit_m12_gone got=%b exp=0", active_mask[0]); end
    end
    tick(1, 1, 0);
    wait_spawn0(ok);
    if (ok) steer(0, -11, ok);
    checks++; if (!ok) begin failures++; $display("FAIL exit_setup2 got=0 exp=1"); end
    if (ok) begin
      tick(0, 1, 4);
      e = 11'(-15);
      checks++; if (active_mask[0] !== 1'b1) begin failures++; $display("FAIL exit_m11_valid got=%b exp=1", active_mask[0]); end
      checks++; if (dbg_x[0] !== e) begin failures++; $display("FAIL exit_m11_x got=%0d exp=-15", $signed(dbg_x[0])); end
    end
  endtask

  task automatic test_pixel();
    int th [5] = '{100, 115, 116, 100, 99};
    int tv [5] = '{360, 399, 380, 359, 380};
    bit te [5] = '{1, 1, 0, 0, 0};
    bit seen_tall = 0, seen_short = 0, ok;
    for (int r = 0; r < 12 && !(seen_tall && seen_short); r++) begin
      tick(1, 1, 0);
      wait_spawn0(ok);
      if (ok) steer(0, 100, ok);
      if (ok) begin
        checks++; if (dbg_tall[0] !== m_tall[0]) begin failures++; $display("FAIL pixel_tall_bit got=%b exp=%b", dbg_tall[0], m_tall[0]); end
        if (m_tall[0] && !seen_tall) begin
          seen_tall = 1;
          for (int k = 0; k < 5; k++) begin
            h_cnt = 10'(th[k]); v_cnt = 10'(tv[k]); #1;
            checks++; if (black_cactus !== te[k]) begin failures++; $display("FAIL pixel_tall (%0d,%0d) got=%b exp=%b", th[k], tv[k], black_cactus, te[k]); end
          end
        end else if (!m_tall[0] && !seen_short) begin
          seen_short = 1;
          h_cnt = 100; v_cnt = 376; #1;
          checks++; if (black_cactus !== 1'b1) begin failures++; $display("FAIL pixel_short_in got=%b exp=1", black_cactus); end
          v_cnt = 375; #1;
          checks++; if (black_cactus !== 1'b0) begin failures++; $display("FAIL pixel_short_above got=%b exp=0", black_cactus); end
        end
      end
    end
    checks++; if (!(seen_tall && seen_short)) begin failures++; $display("FAIL pixel_coverage got=%b%b exp=11", seen_tall, seen_short); end
  endtask

  task automatic test_full();
    bit reached = 0;
    int s, thr, held_gap, exit_slot = -1;
    tick(1, 1, 0);
    // Keep spawns tightly packed: wait at gap 200 (speed 0 rerolls the LFSR)
    // until the threshold is within reach.
    for (int n = 0; n < 4000 && !reached; n++) begin
      if (m_spawn) s = 0;
      else begin
        thr = 200 + int'(m_lfsr[7:0]);
        if (m_gap < 200) s = (200 - m_gap > 15) ? 15 : 200 - m_gap;
        else if (thr - m_gap <= 2) s = (thr - m_gap < 0) ? 0 : thr - m_gap;
        else s = 0;
      end
      tick(0, 1, s);
      if (m_spawn && model_mask() == 3'b111) reached = 1;
    end
    checks++; if (!reached) begin failures++; $display("FAIL full_reach got=0 exp=1"); end
    if (!reached) return;
    checks++; if (dbg_state !== ST_SPAWN) begin failures++; $display("FAIL full_state got=%0d exp=1", dbg_state); end
    checks++; if (active_mask !== 3'b111) begin failures++; $display("FAIL full_mask got=%b exp=111", active_mask); end
    held_gap = m_gap;
    for (int t = 0; t < 200; t++) begin
      tick(0, 1, 4);
      checks++; if (dbg_gap_cnt !== 10'(held_gap)) begin failures++; $display("FAIL full_gap_held got=%0d exp=%0d", dbg_gap_cnt, held_gap); end
      checks++; if (dbg_lfsr !== m_lfsr) begin failures++; $display("FAIL full_lfsr got=%h exp=%h", dbg_lfsr, m_lfsr); end
      if (model_mask() != 3'b111) begin
        for (int i = NS - 1; i >= 0; i--) if (!m_valid[i]) exit_slot = i;
        break;
      end
    end
    checks++; if (exit_slot < 0) begin failures++; $display("FAIL full_exit got=none exp=slot"); end
    if (exit_slot < 0) return;
    checks++; if (dbg_state !== ST_SPAWN) begin failures++; $display("FAIL full_exit_state got=%0d exp=1", dbg_state); end
    checks++; if (active_mask !== model_mask()) begin failures++; $display("FAIL full_exit_mask got=%b exp=%b", active_mask, model_mask()); end
    tick(0, 1, 4);
    checks++; if (active_mask[exit_slot] !== 1'b1) begin failures++; $display("FAIL full_respawn slot=%0d got=0 exp=1", exit_slot); end
    checks++; if (dbg_x[exit_slot] !== 11'd640) begin failures++; $display("FAIL full_respawn_x got=%0d exp=640", $signed(dbg_x[exit_slot])); end
    checks++; if (dbg_state !== ST_GAP || dbg_gap_cnt !== 10'd0) begin failures++; $display("FAIL full_respawn_fsm got=%0d/%0d exp=0/0", dbg_state, dbg_gap_cnt); end
  endtask

  task automatic test_freeze_clear();
    logic [15:0] saved_lfsr;
    int ph = 0, pv = 380;
    for (int n = 0; n < 100 && model_mask() == 3'b000; n++) tick(0, 1, 15);
    for (int i = NS - 1; i >= 0; i--) if (m_valid[i]) ph = (m_x[i] < 0) ? 0 : m_x[i];
    pv = 399;
    saved_lfsr = m_lfsr;
    for (int t = 0; t < 10; t++) begin
      tick(0, 0, $urandom_range(1, 15));
      checks++; if (dbg_gap_cnt !== 10'(m_gap) || dbg_lfsr !== saved_lfsr) begin failures++; $display("FAIL freeze_gap_lfsr got=%0d/%h exp=%0d/%h", dbg_gap_cnt, dbg_lfsr, m_gap, saved_lfsr); end
      for (int i = 0; i < NS; i++) if (m_valid[i]) begin
        checks++; if (dbg_x[i] !== 11'(m_x[i])) begin failures++; $display("FAIL freeze_x%0d got=%0d exp=%0d", i, $signed(dbg_x[i]), m_x[i]); end
      end
    end
    h_cnt = 10'(ph); v_cnt = 10'(pv); #1;
    checks++; if (black_cactus !== model_pixel(ph, pv)) begin failures++; $display("FAIL freeze_black got=%b exp=%b", black_cactus, model_pixel(ph, pv)); end
    tick(1, 1, 7);
    #1;
    checks++; if (active_mask !== 3'b000) begin failures++; $display("FAIL clear_mask got=%b exp=000", active_mask); end
    checks++; if (dbg_gap_cnt !== 10'd0 || dbg_state !== ST_GAP) begin failures++; $display("FAIL clear_fsm got=%0d/%0d exp=0/0", dbg_gap_cnt, dbg_state); end
    checks++; if (black_cactus !== 1'b0) begin failures++; $display("FAIL clear_black got=%b exp=0", black_cactus); end
    checks++; if (dbg_lfsr !== saved_lfsr) begin failures++; $display("FAIL clear_lfsr got=%h exp=%h", dbg_lfsr, saved_lfsr); end
  endtask

  task automatic test_random();
    int s, h, v, sl;
    bit c, r;
    for (int n = 0; n < 400; n++) begin
      c = ($urandom_range(0, 49) == 0);
      r = ($urandom_range(0, 9) != 0);
      s = $urandom_range(0, 15);
      tick(c, r, s);
      checks++; if (active_mask !== model_mask()) begin failures++; $display("FAIL rand_mask n=%0d got=%b exp=%b", n, active_mask, model_mask()); end
      checks++; if (dbg_gap_cnt !== 10'(m_gap) || dbg_lfsr !== m_lfsr) begin failures++; $display("FAIL rand_gap_lfsr n=%0d got=%0d/%h exp=%0d/%h", n, dbg_gap_cnt, dbg_lfsr, m_gap, m_lfsr); end
      checks++; if (dbg_state !== (m_spawn ? ST_SPAWN : ST_GAP)) begin failures++; $display("FAIL rand_state n=%0d got=%0d exp=%0d", n, dbg_state, m_spawn); end
      for (int i = 0; i < NS; i++) if (m_valid[i]) begin
        checks++; if (dbg_x[i] !== 11'(m_x[i]) || dbg_tall[i] !== m_tall[i]) begin failures++; $display("FAIL rand_slot%0d n=%0d got=%0d/%b exp=%0d/%b", i, n, $signed(dbg_x[i]), dbg_tall[i], m_x[i], m_tall[i]); end
      end
      sl = $urandom_range(0, NS - 1);
      h = m_valid[sl] ? m_x[sl] + $urandom_range(0, 17) - 1 : $urandom_range(0, 1023);
      if (h < 0) h = 0;
      if (h > 1023) h = 1023;
      v = $urandom_range(350, 405);
      h_cnt = 10'(h); v_cnt = 10'(v); #1;
      checks++; if (black_cactus !== model_pixel(h, v)) begin failures++; $display("FAIL rand_pixel (%0d,%0d) got=%b exp=%b", h, v, black_cactus, model_pixel(h, v)); end
    end
  endtask

  task automatic test_async_reset();
    int ph = 0;
    for (int n = 0; n < 100 && model_mask() == 3'b000; n++) tick(0, 1, 15);
    for (int i = NS - 1; i >= 0; i--) if (m_valid[i]) ph = (m_x[i] < 0) ? 0 : m_x[i];
    h_cnt = 10'(ph); v_cnt = 399;
    @(negedge clk); #2;
    checks++; if (black_cactus !== model_pixel(ph, 399)) begin failures++; $display("FAIL areset_pre_black got=%b exp=%b", black_cactus, model_pixel(ph, 399)); end
    rst_n = 0; #1;
    checks++; if (active_mask !== 3'b000) begin failures++; $display("FAIL areset_mask got=%b exp=000", active_mask); end
    checks++; if (black_cactus !== 1'b0) begin failures++; $display("FAIL areset_black got=%b exp=0", black_cactus); end
    repeat (3) @(negedge clk);
    rst_n = 1;
    model_reset();
    @(negedge clk);
    checks++; if (dbg_lfsr !== 16'hACE1) begin failures++; $display("FAIL areset_lfsr got=%h exp=ace1", dbg_lfsr); end
    checks++; if (dbg_state !== ST_GAP || dbg_gap_cnt !== 10'd0) begin failures++; $display("FAIL areset_fsm got=%0d/%0d exp=0/0", dbg_state, dbg_gap_cnt); end
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_exit();
    test_pixel();
    test_full();
    test_freeze_clear();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
